branch_predict_fetch: RTL and testbench
=======================================

Name: branch_predict_fetch

Overview:
Fetch-stage PC generator for the pipelined core. It is the parametrised successor to the single-cycle PC register and next-PC logic. It holds the architectural fetch PC and predicts the next PC with a direct-mapped branch target buffer (BTB) using saturating direction counters. It accepts redirects and training updates from the execute stage. It sits between the request unit (stall/advance) and the instruction cache address port.

Parameters:
PC_INIT, 32'h0, reset value of the fetch PC
ENTRIES, 16, number of BTB entries; power of two, 2..256
CTR_BITS, 2, width of each direction counter; 1..4
(derived) IDX_BITS = log2(ENTRIES), TAG_BITS = 30 - IDX_BITS

Ports:
CLK  input  1  clock; all state updates on the rising edge
nRST  input  1  asynchronous active-low reset
adv  input  1  fetch advances this cycle (request unit ihit and no pipeline stall)
halt  input  1  freeze the PC; takes priority over adv
redirect_en  input  1  execute-stage mispredict or jump correction
redirect_pc  input  32  corrected PC
upd_en  input  1  resolved branch/jump training update
upd_pc  input  32  PC of the resolved instruction
upd_taken  input  1  resolved direction
upd_target  input  32  resolved taken target
pc  output  32  current fetch PC (to imemaddr)
pred_hit  output  1  BTB hit for pc
pred_taken  output  1  predicted taken for pc
pred_target  output  32  predicted next PC for pc (pipelined with the instruction)
redirect_count  output  32  saturating count of accepted redirects

Behaviour:
- Reset (asynchronous, nRST low):
  - pc = PC_INIT.
  - All valid bits cleared, so pred_hit = 0 and pred_taken = 0.
  - redirect_count = 0.
  - Tags, targets and counters need no reset.
- Indexing: idx = pc[IDX_BITS+1:2]; tag = pc[31:IDX_BITS+2]. Bits [1:0] are ignored. The same mapping applies to upd_pc.
- Lookup (combinational, zero latency, from the current pc):
  - pred_hit = valid[idx] && tag match.
  - pred_taken = pred_hit && counter MSB.
  - pred_target = pred_taken ? stored target : pc + 4. The +4 wraps modulo 2^32.
- PC update at the edge, in priority order:
  - !nRST → PC_INIT.
  - halt → hold. Redirects are ignored while halted.
  - redirect_en → redirect_pc. This applies regardless of adv, so a stalled fetch is still corrected.
  - adv → pred_target.
  - otherwise → hold.
- redirect_count increments on each cycle where redirect_en && !halt. It saturates at 32'hFFFFFFFF and does not wrap.
- Training, on upd_en at the edge:
  - Tag hit at upd_pc's index:
    - Counter increments when upd_taken and decrements otherwise.
    - Counter saturates at 0 and at 2^CTR_BITS−1.
    - When upd_taken, target is overwritten with upd_target.
  - Miss with upd_taken: allocate by replacing whatever occupies the index. Set valid = 1, tag and target from the update, and counter = weakly taken (MSB set, other bits 0; 2'b10 for CTR_BITS = 2).
  - Miss with !upd_taken: no change.
- Simultaneous update and lookup on the same index:
  - The lookup sees pre-update contents.
  - The new entry is visible from the next cycle.
  - There is no bypass.
- Simultaneous redirect_en and upd_en: both take effect in the same cycle. They are independent.
- halt does not block training.
- Reset mid-operation: an in-flight update is discarded, and all entries are invalid after reset.

Decomposition:
- Shared package (cpu_types_pkg): word_t is reused. Add the btb_entry_t struct (valid, tag, target, ctr) and the WEAK_TAKEN constant function of CTR_BITS.
- One sub-module: sat_counter. It is a combinational CTR_BITS-wide inc/dec with saturation, instantiated once on the update path.
- Entry storage is a flip-flop array inside branch_predict_fetch.

Test Plan:
1. Reset, then hold nRST high with adv=1 for 3 cycles and no updates → pc goes 0x0, 0x4, 0x8, 0xC; pred_hit = 0 throughout.
2. Train a branch at 0x10: upd_en, upd_pc=0x10, upd_taken=1, upd_target=0x40. Then redirect to 0x10 with adv=1 → pred_hit=1, pred_taken=1, next pc = 0x40.
3. Starting from state 2, apply two not-taken updates at 0x10: the counter goes 10→01→00. At pc=0x10 this gives pred_hit=1, pred_taken=0, next pc = 0x14. A further not-taken update keeps the counter at 00. Repeat the check with CTR_BITS=3 to confirm saturation at 000 and 111.
4. Aliasing test with ENTRIES=16: after training 0x10, a taken update at 0x50 with target 0x80 replaces the entry → pc=0x10 now misses; pc=0x50 predicts 0x80.
5. Priority test: assert halt=1, redirect_en=1 (redirect_pc=0x100) and adv=1 together → pc holds and redirect_count is unchanged. Drop halt with adv=0 → pc=0x100 and count increments by 1.
6. Apply an update and a lookup at the same index in the same cycle → the old prediction is used that cycle. Preload redirect_count near saturation and drive extra redirects → it stays at 0xFFFFFFFF. Assert nRST asynchronously mid-cycle → pc = PC_INIT immediately and all entries miss.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Types shared across the core: the machine word and the BTB entry layout.
// Entry fields are sized for the widest legal configuration; narrower ones zero-extend.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int MAX_TAG_BITS = 29;
  localparam int MAX_CTR_BITS = 4;

  typedef struct packed {
    logic                    valid;
    logic [MAX_TAG_BITS-1:0] tag;
    word_t                   target;
    logic [MAX_CTR_BITS-1:0] ctr;
  } btb_entry_t;

  // Weakly-taken counter value: MSB set, all lower bits clear.
  function automatic logic [MAX_CTR_BITS-1:0] WEAK_TAKEN(input int ctr_bits);
    return 4'b0001 << (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/branch_predict_fetch_sat_counter.sv
// Combinational up/down counter that sticks at zero and at all-ones.
module sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr,
  input  logic                inc,
  output logic [CTR_BITS-1:0] ctr_next
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);

  always_comb begin
    ctr_next = ctr;
    if (inc) begin
      if (ctr != CTR_MAX) ctr_next = ctr + CTR_ONE;
    end else begin
      if (ctr != '0) ctr_next = ctr - CTR_ONE;
    end
  end

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch PC register with a direct-mapped BTB predicting the next fetch address.
// Execute-stage redirects and training updates arrive independently each cycle.
module branch_predict_fetch
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT  = 32'h0,
  parameter int    ENTRIES  = 16,
  parameter int    CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        adv,
  input  logic        halt,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  output logic [31:0] redirect_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = 30 - IDX_BITS;

  btb_entry_t btb_reg [ENTRIES];

  word_t pc_reg;
  word_t pc_next;
  word_t redirect_count_reg;
  word_t redirect_count_next;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;

  btb_entry_t          lk_entry;
  btb_entry_t          up_entry;
  btb_entry_t          wr_entry;
  logic                wr_en;
  logic                upd_hit;
  logic [CTR_BITS-1:0] ctr_upd;
  logic                unused_bits;

  // Lookup reads the array as it stands; same-cycle writes appear next cycle.
  assign lk_idx   = pc_reg[IDX_BITS+1:2];
  assign lk_tag   = pc_reg[31:IDX_BITS+2];
  assign lk_entry = btb_reg[lk_idx];

  assign pred_hit    = lk_entry.valid && (lk_entry.tag == MAX_TAG_BITS'(lk_tag));
  assign pred_taken  = pred_hit && lk_entry.ctr[CTR_BITS-1];
  assign pred_target = pred_taken ? lk_entry.target : (pc_reg + 32'd4);

  assign upd_idx  = upd_pc[IDX_BITS+1:2];
  assign upd_tag  = upd_pc[31:IDX_BITS+2];
  assign up_entry = btb_reg[upd_idx];
  assign upd_hit  = up_entry.valid && (up_entry.tag == MAX_TAG_BITS'(upd_tag));

  sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr      (up_entry.ctr[CTR_BITS-1:0]),
    .inc      (upd_taken),
    .ctr_next (ctr_upd)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (upd_en) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = MAX_CTR_BITS'(ctr_upd);
        if (upd_taken) wr_entry.target = upd_target;
      end else if (upd_taken) begin
        // Allocation evicts whatever currently owns this index.
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = MAX_TAG_BITS'(upd_tag);
        wr_entry.target = upd_target;
        wr_entry.ctr    = WEAK_TAKEN(CTR_BITS);
      end
    end
  end

  always_comb begin
    pc_next = pc_reg;
    if (halt) begin
      pc_next = pc_reg;
    end else if (redirect_en) begin
      pc_next = redirect_pc;
    end else if (adv) begin
      pc_next = pred_target;
    end
  end

  always_comb begin
    redirect_count_next = redirect_count_reg;
    if (redirect_en && !halt && (redirect_count_reg != 32'hFFFF_FFFF)) begin
      redirect_count_next = redirect_count_reg + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_reg             <= PC_INIT;
      redirect_count_reg <= '0;
    end else begin
      pc_reg             <= pc_next;
      redirect_count_reg <= redirect_count_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) btb_reg[i] <= '0;
    end else if (wr_en) begin
      btb_reg[upd_idx] <= wr_entry;
    end
  end

  assign pc             = pc_reg;
  assign redirect_count = redirect_count_reg;

  assign unused_bits = ^{upd_pc[1:0], lk_entry.ctr, up_entry.ctr};

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Directed bench for branch_predict_fetch; a 2-bit and a 3-bit counter build run side by side.
module tb_branch_predict_fetch;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        adv;
  logic        halt;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  logic [31:0] pc, pred_target, redirect_count;
  logic        pred_hit, pred_taken;
  logic [31:0] pc3, target3, count3;
  logic        hit3, taken3;

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] exp_count;

  always #5 CLK = ~CLK;

  branch_predict_fetch #(.PC_INIT(32'h0), .ENTRIES(16), .CTR_BITS(2)) dut (
    .CLK(CLK), .nRST(nRST), .adv(adv), .halt(halt),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .redirect_count(redirect_count)
  );

  branch_predict_fetch #(.PC_INIT(32'h0), .ENTRIES(16), .CTR_BITS(3)) dut3 (
    .CLK(CLK), .nRST(nRST), .adv(adv), .halt(halt),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .pc(pc3), .pred_hit(hit3), .pred_taken(taken3),
    .pred_target(target3), .redirect_count(count3)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_upd(input logic [31:0] p, input logic t, input logic [31:0] tgt);
    upd_en = 1'b1; upd_pc = p; upd_taken = t; upd_target = tgt;
    tick();
    upd_en = 1'b0;
    $display("upd pc=%h taken=%0b target=%h", p, t, tgt);
  endtask

  task automatic do_redirect(input logic [31:0] p);
    redirect_en = 1'b1; redirect_pc = p;
    tick();
    redirect_en = 1'b0;
    exp_count = exp_count + 32'd1;
    $display("redirect pc=%h", p);
  endtask

  task automatic test_reset();
    nRST = 1'b1;
    #2 nRST = 1'b0;
    #2;
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (pc3 !== 32'h0) begin n_fail++; $display("FAIL reset_pc3: got %h want %h", pc3, 32'h0); end
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", pred_hit); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", pred_taken); end
    n_cmp++; if (redirect_count !== 32'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0", redirect_count); end
    @(negedge CLK);
    nRST = 1'b1; adv = 1'b1; exp_count = 32'h0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (pc !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc%0d: got %h want %h", i, pc, 32'(4 * i)); end
      n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL seq_hit%0d: got %b want 0", i, pred_hit); end
      $display("fetch pc=%h", pc);
      if (i < 3) tick();
    end
    adv = 1'b0;
  endtask

  task automatic test_train_taken();
    do_upd(32'h10, 1'b1, 32'h40);
    do_redirect(32'h10);
    n_cmp++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL train_hit: got %b want 1", pred_hit); end
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_taken: got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h40) begin n_fail++; $display("FAIL train_target: got %h want %h", pred_target, 32'h40); end
    n_cmp++; if (taken3 !== 1'b1) begin n_fail++; $display("FAIL train_taken3: got %b want 1", taken3); end
    adv = 1'b1; tick(); adv = 1'b0;
    n_cmp++; if (pc !== 32'h40) begin n_fail++; $display("FAIL train_next_pc: got %h want %h", pc, 32'h40); end
    n_cmp++; if (redirect_count !== exp_count) begin n_fail++; $display("FAIL train_count: got %h want %h", redirect_count, exp_count); end
  endtask

  task automatic test_not_taken();
    // 2-bit starts at 10, 3-bit at 100
    do_redirect(32'h10);
    do_upd(32'h10, 1'b0, 32'h0);   // 01 / 011
    n_cmp++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL nt1_hit: got %b want 1", pred_hit); end
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt1_taken: got %b want 0", pred_taken); end
    n_cmp++; if (pred_target !== 32'h14) begin n_fail++; $display("FAIL nt1_target: got %h want %h", pred_target, 32'h14); end
    n_cmp++; if (taken3 !== 1'b0) begin n_fail++; $display("FAIL nt1_taken3: got %b want 0", taken3); end
    do_upd(32'h10, 1'b0, 32'h0);   // 00 / 010
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL nt2_taken: got %b want 0", pred_taken); end
    adv = 1'b1; tick(); adv = 1'b0;
    n_cmp++; if (pc !== 32'h14) begin n_fail++; $display("FAIL nt2_next_pc: got %h want %h", pc, 32'h14); end
    do_redirect(32'h10);
    do_upd(32'h10, 1'b0, 32'h0);   // 00 / 001
    do_upd(32'h10, 1'b1, 32'h40);  // 01 / 010
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat0_taken: got %b want 0", pred_taken); end
    n_cmp++; if (taken3 !== 1'b0) begin n_fail++; $display("FAIL sat0_taken3a: got %b want 0", taken3); end
    for (int i = 0; i < 3; i++) do_upd(32'h10, 1'b0, 32'h0);  // 00 / 000
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL sat0_taken_b: got %b want 0", pred_taken); end
    n_cmp++; if (taken3 !== 1'b0) begin n_fail++; $display("FAIL sat0_taken3b: got %b want 0", taken3); end
    n_cmp++; if (hit3 !== 1'b1) begin n_fail++; $display("FAIL sat0_hit3: got %b want 1", hit3); end
    for (int i = 0; i < 8; i++) do_upd(32'h10, 1'b1, 32'h40); // 11 / 111
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL satmax_taken: got %b want 1", pred_taken); end
    n_cmp++; if (taken3 !== 1'b1) begin n_fail++; $display("FAIL satmax_taken3: got %b want 1", taken3); end
    n_cmp++; if (target3 !== 32'h40) begin n_fail++; $display("FAIL satmax_target3: got %h want %h", target3, 32'h40); end
    for (int i = 0; i < 3; i++) do_upd(32'h10, 1'b0, 32'h0);  // 00 / 100
    n_cmp++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL satmax_down: got %b want 0", pred_taken); end
    n_cmp++; if (taken3 !== 1'b1) begin n_fail++; $display("FAIL satmax_down3: got %b want 1", taken3); end
    do_upd(32'h10, 1'b0, 32'h0);   // 00 / 011
    n_cmp++; if (taken3 !== 1'b0) begin n_fail++; $display("FAIL satmax_down3b: got %b want 0", taken3); end
  endtask

  task automatic test_alias();
    n_cmp++; if (pred_hit !== 1'b1) begin n_fail++; $display("FAIL alias_pre_hit: got %b want 1", pred_hit); end
    do_upd(32'h50, 1'b1, 32'h80);
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL alias_evict_hit: got %b want 0", pred_hit); end
    n_cmp++; if (pred_target !== 32'h14) begin n_fail++; $display("FAIL alias_evict_target: got %h want %h", pred_target, 32'h14); end
    do_redirect(32'h50);
    n_cmp++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_new_taken: got %b want 1", pred_taken); end
    n_cmp++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL alias_new_target: got %h want %h", pred_target, 32'h80); end
    adv = 1'b1; tick(); adv = 1'b0;
    n_cmp++; if (pc !== 32'h80) begin n_fail++; $display("FAIL alias_next_pc: got %h want %h", pc, 32'h80); end
    n_cmp++; if (pc3 !== 32'h80) begin n_fail++; $display("FAIL alias_next_pc3: got %h want %h", pc3, 32'h80); end
  endtask

  task automatic test_priority();
    halt = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h100; adv = 1'b1;
    tick();
    $display("halt+redirect+adv pc=%h", pc);
    n_cmp++; if (pc !== 32'h80) begin n_fail++; $display("FAIL prio_hold_pc: got %h want %h", pc, 32'h80); end
    n_cmp++; if (redirect_count !== exp_count) begin n_fail++; $display("FAIL prio_hold_count: got %h want %h", redirect_count, exp_count); end
    halt = 1'b0; adv = 1'b0;
    tick();
    redirect_en = 1'b0; exp_count = exp_count + 32'd1;
    $display("redirect (no adv) pc=%h", pc);
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL prio_redir_pc: got %h want %h", pc, 32'h100); end
    n_cmp++; if (redirect_count !== exp_count) begin n_fail++; $display("FAIL prio_redir_count: got %h want %h", redirect_count, exp_count); end
    // Training still lands while the PC is frozen
    halt = 1'b1; adv = 1'b1;
    do_upd(32'h104, 1'b1, 32'h300);
    halt = 1'b0; adv = 1'b0;
    n_cmp++; if (pc !== 32'h100) begin n_fail++; $display("FAIL halt_train_pc: got %h want %h", pc, 32'h100); end
    do_redirect(32'h104);
    n_cmp++; if (pred_target !== 32'h300) begin n_fail++; $display("FAIL halt_train_target: got %h want %h", pred_target, 32'h300); end
  endtask

  task automatic test_same_index();
    do_redirect(32'h100);
    upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1; upd_target = 32'h200; adv = 1'b1;
    #1;
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL same_idx_hit: got %b want 0", pred_hit); end
    tick();
    upd_en = 1'b0; adv = 1'b0;
    $display("upd+lookup pc=%h", pc);
    n_cmp++; if (pc !== 32'h104) begin n_fail++; $display("FAIL same_idx_pc: got %h want %h", pc, 32'h104); end
    do_redirect(32'h100);
    n_cmp++; if (pred_target !== 32'h200) begin n_fail++; $display("FAIL same_idx_next: got %h want %h", pred_target, 32'h200); end
    // Redirect and training in one cycle both take effect
    redirect_en = 1'b1; redirect_pc = 32'h108;
    upd_en = 1'b1; upd_pc = 32'h108; upd_taken = 1'b1; upd_target = 32'h400;
    tick();
    redirect_en = 1'b0; upd_en = 1'b0; exp_count = exp_count + 32'd1;
    $display("redirect+upd pc=%h", pc);
    n_cmp++; if (pc !== 32'h108) begin n_fail++; $display("FAIL both_pc: got %h want %h", pc, 32'h108); end
    n_cmp++; if (pred_target !== 32'h400) begin n_fail++; $display("FAIL both_target: got %h want %h", pred_target, 32'h400); end
    n_cmp++; if (redirect_count !== exp_count) begin n_fail++; $display("FAIL both_count: got %h want %h", redirect_count, exp_count); end
  endtask

  task automatic test_count_sat();
    logic [31:0] exp;
    dut.redirect_count_reg = 32'hFFFF_FFFD;
    exp = 32'hFFFF_FFFD;
    redirect_en = 1'b1; redirect_pc = 32'h200;
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = (exp == 32'hFFFF_FFFF) ? exp : exp + 32'd1;
      $display("redirect count=%h", redirect_count);
      n_cmp++; if (redirect_count !== exp) begin n_fail++; $display("FAIL sat_count%0d: got %h want %h", i, redirect_count, exp); end
    end
    redirect_en = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    n_cmp++; if (pc !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (redirect_count !== 32'h0) begin n_fail++; $display("FAIL areset_count: got %h want 0", redirect_count); end
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL areset_hit: got %b want 0", pred_hit); end
    upd_en = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h99;
    tick();
    upd_en = 1'b0;
    @(negedge CLK);
    nRST = 1'b1; exp_count = 32'h0;
    do_redirect(32'h10);
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL areset_miss10: got %b want 0", pred_hit); end
    do_redirect(32'h50);
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL areset_miss50: got %b want 0", pred_hit); end
    do_redirect(32'h20);
    n_cmp++; if (pred_hit !== 1'b0) begin n_fail++; $display("FAIL areset_miss20: got %b want 0", pred_hit); end
    n_cmp++; if (redirect_count !== exp_count) begin n_fail++; $display("FAIL areset_count_after: got %h want %h", redirect_count, exp_count); end
  endtask

  initial begin
    nRST = 1'b1; adv = 1'b0; halt = 1'b0;
    redirect_en = 1'b0; redirect_pc = 32'h0;
    upd_en = 1'b0; upd_pc = 32'h0; upd_taken = 1'b0; upd_target = 32'h0;
    exp_count = 32'h0;
    test_reset();
    test_train_taken();
    test_not_taken();
    test_alias();
    test_priority();
    test_same_index();
    test_count_sat();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
